disp_mux_bcd: RTL and testbench

//   Time-multiplexed 4-digit seven-segment driver; consumes the four BCD digits from the rotating banner.

---
 rtl/disp_pkg.sv | 22 ++
 rtl/bcd_to_sseg.sv | 27 ++
 rtl/disp_mux_bcd.sv | 79 +++++++
 tb/tb_disp_mux_bcd.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed seven-segment driver.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package disp_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0    = 7'h40;
  localparam seg_t SEG_1    = 7'h79;
  localparam seg_t SEG_2    = 7'h24;
  localparam seg_t SEG_3    = 7'h30;
  localparam seg_t SEG_4    = 7'h19;
  localparam seg_t SEG_5    = 7'h12;
  localparam seg_t SEG_6    = 7'h02;
  localparam seg_t SEG_7    = 7'h78;
  localparam seg_t SEG_8    = 7'h00;
  localparam seg_t SEG_9    = 7'h10;
  localparam seg_t SEG_DASH = 7'h3F;
  localparam seg_t SEG_OFF  = 7'h7F;
  localparam logic [3:0] AN_OFF = 4'hF;

endpackage

// File: rtl/bcd_to_sseg.sv
// Combinational BCD to active-low seven-segment decoder.
// Non-decimal codes render as a single dash.
module bcd_to_sseg
  import disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/disp_mux_bcd.sv
// Four-digit time-multiplexed seven-segment driver with per-frame digit
// snapshot, PWM brightness, global blank and optional leading-zero blanking.
module disp_mux_bcd
  import disp_pkg::*;
#(
  parameter int REFRESH_POWER = 18,
  parameter bit LZB           = 1'b0
)(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] bcd_0,
  input  logic [3:0] bcd_1,
  input  logic [3:0] bcd_2,
  input  logic [3:0] bcd_3,
  input  logic [3:0] dp_in,
  input  logic [2:0] brightness,
  input  logic       disp_en,
  output logic [3:0] an,
  output logic [7:0] sseg
);

  localparam int N = REFRESH_POWER;

  logic [N-1:0]    r_q;
  logic [3:0][3:0] r_digit_snap;
  logic [3:0]      r_dp_snap;

  logic [1:0] w_sel;
  logic [2:0] w_duty;
  logic       w_lit;
  logic [3:0] w_blank;
  logic [3:0] w_digit;
  logic [6:0] w_seg_dec;
  logic [6:0] w_seg;

  assign w_sel  = r_q[N-1 -: 2];
  assign w_duty = r_q[N-3 -: 3];
  assign w_lit  = disp_en && (w_duty <= brightness);

  // A digit is a leading zero when it and every digit to its left are zero.
  assign w_blank[3] = LZB && (r_digit_snap[3] == 4'd0);
  assign w_blank[2] = w_blank[3] && (r_digit_snap[2] == 4'd0);
  assign w_blank[1] = w_blank[2] && (r_digit_snap[1] == 4'd0);
  assign w_blank[0] = 1'b0;

  assign w_digit = r_digit_snap[w_sel];

  bcd_to_sseg u_dec (
    .i_bcd (w_digit),
    .o_seg (w_seg_dec)
  );

  assign w_seg = w_blank[w_sel] ? SEG_OFF : w_seg_dec;

  // Snapshot is taken on the last cycle of a frame so the whole next frame is coherent.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q          <= '0;
      r_digit_snap <= '0;
      r_dp_snap    <= '0;
      an           <= AN_OFF;
      sseg         <= {1'b1, SEG_OFF};
    end else begin
      r_q <= r_q + N'(1);
      if (&r_q) begin
        r_digit_snap <= {bcd_3, bcd_2, bcd_1, bcd_0};
        r_dp_snap    <= dp_in;
      end
      if (w_lit) begin
        an   <= ~(4'b0001 << w_sel);
        sseg <= {~r_dp_snap[w_sel], w_seg};
      end else begin
        an   <= AN_OFF;
        sseg <= {1'b1, SEG_OFF};
      end
    end
  end

endmodule

// File: tb/tb_disp_mux_bcd.sv
// Bench for disp_mux_bcd: two instances (LZB off/on) at REFRESH_POWER=6 driven
// with directed and random stimulus, checked every cycle against a frame-level model.
module tb_disp_mux_bcd;

  logic       clk;
  logic       rst;
  logic [3:0] b0, b1, b2, b3;
  logic [3:0] dp;
  logic [2:0] br;
  logic       en;
  logic [3:0] an0, an1;
  logic [7:0] ss0, ss1;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  int         m_q;
  int         m_dig [4];
  int         m_dp  [4];
  logic [3:0] e_an  [2];
  logic [7:0] e_ss  [2];

  disp_mux_bcd #(.REFRESH_POWER(6), .LZB(1'b0)) dut0 (
    .clk(clk), .reset(rst), .bcd_0(b0), .bcd_1(b1), .bcd_2(b2), .bcd_3(b3),
    .dp_in(dp), .brightness(br), .disp_en(en), .an(an0), .sseg(ss0)
  );

  disp_mux_bcd #(.REFRESH_POWER(6), .LZB(1'b1)) dut1 (
    .clk(clk), .reset(rst), .bcd_0(b0), .bcd_1(b1), .bcd_2(b2), .bcd_3(b3),
    .dp_in(dp), .brightness(br), .disp_en(en), .an(an1), .sseg(ss1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t model_q=%0d)", tag, obs, exp_v, $time, m_q);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tab [16];
    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    return tab[d];
  endfunction

  // One clock: compute what the outputs must become at this edge, then compare.
  task automatic step();
    int  sel, duty, k;
    bit  lit, blank;
    @(posedge clk);
    if (rst) begin
      m_q = 0;
      for (int i = 0; i < 4; i++) begin m_dig[i] = 0; m_dp[i] = 0; end
      for (int z = 0; z < 2; z++) begin e_an[z] = 4'hF; e_ss[z] = 8'hFF; end
    end else begin
      sel  = m_q / 16;
      duty = (m_q % 16) / 2;
      lit  = en && (duty <= int'(br));
      for (int z = 0; z < 2; z++) begin
        blank = 1'b0;
        if (z == 1 && sel >= 1) begin
          blank = 1'b1;
          for (k = sel; k < 4; k++) if (m_dig[k] != 0) blank = 1'b0;
        end
        if (lit) begin
          e_an[z] = 4'hF;
          e_an[z][sel] = 1'b0;
          e_ss[z] = {(m_dp[sel] == 0), (blank ? 7'h7F : seg_of(m_dig[sel]))};
        end else begin
          e_an[z] = 4'hF;
          e_ss[z] = 8'hFF;
        end
      end
      if (m_q == 63) begin
        m_dig[0] = int'(b0); m_dig[1] = int'(b1); m_dig[2] = int'(b2); m_dig[3] = int'(b3);
        for (int i = 0; i < 4; i++) m_dp[i] = int'(dp[i]);
      end
      m_q = (m_q + 1) % 64;
    end
    #1;
    chk("an_lzb0",   {4'h0, an0}, {4'h0, e_an[0]});
    chk("sseg_lzb0", ss0, e_ss[0]);
    chk("an_lzb1",   {4'h0, an1}, {4'h0, e_an[1]});
    chk("sseg_lzb1", ss1, e_ss[1]);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [3:0] rnd_digit();
    return ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; br = 3'd0; dp = 4'h0;
    b0 = 4'd0; b1 = 4'd0; b2 = 4'd0; b3 = 4'd0;
    m_q = 0;
    run(3);

    // counting digits at full brightness: frame 0 shows zeros, frame 1 shows 3210
    rst = 1'b0; en = 1'b1; br = 3'd7;
    b3 = 4'd3; b2 = 4'd2; b1 = 4'd1; b0 = 4'd0;
    run(128);

    // mid-frame change must wait for the next frame
    for (int i = 0; i < 64 && m_q != 20; i++) step();
    b0 = 4'd9;
    run(128);

    // brightness boundaries
    br = 3'd0; run(64);
    br = 3'd3; run(64);
    br = 3'd7;

    // dash with decimal point, then global blank
    b2 = 4'hB; dp = 4'b0100; run(128);
    en = 1'b0; run(64);
    en = 1'b1;

    // leading zeros {0,0,4,0}
    b3 = 4'd0; b2 = 4'd0; b1 = 4'd4; b0 = 4'd0; dp = 4'h0;
    run(128);

    // randomized traffic with occasional mid-frame reset
    for (int i = 0; i < 1600; i++) begin
      if ($urandom_range(0, 15) == 0) b0 = rnd_digit();
      if ($urandom_range(0, 15) == 0) b1 = rnd_digit();
      if ($urandom_range(0, 15) == 0) b2 = rnd_digit();
      if ($urandom_range(0, 15) == 0) b3 = rnd_digit();
      if ($urandom_range(0, 31) == 0) dp = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) br = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 63) == 0) en = ~en;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    run(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
